// File: rtl/ddr3_mp_frontend_if.sv
// Bundle of client-side, downstream-command and return-path signals for the
// multi-port DDR3 front end. The front end itself uses the slave modport.
//
// Handshakes:
//   client request : cmd[p] is a one-cycle offer. It is taken at the edge when
//                    notfull[p]=1 and cmd[p] is SCR/SCW, otherwise it is dropped.
//   downstream     : out_valid/out_get. The entry transfers at the edge where
//                    out_valid=1 and out_get=1. out_get with out_valid=0 does nothing.
//   return put     : ret_put is a one-cycle offer. It is taken when the selected
//                    return FIFO has room or is read in the same cycle.
//   return read    : validout[p]/read[p]. The head pops at the edge where both are 1.
interface ddr3_mp_frontend_if #(
  parameter int NPORTS   = 2,
  parameter int DW       = 16,
  parameter int AW       = 26,
  parameter int DEPTH_P2 = 4
);
  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int OCW = PW + 3 + AW + 5;

  logic [3*NPORTS-1:0]            cmd;
  logic [AW*NPORTS-1:0]           addr;
  logic [2*NPORTS-1:0]            sz;
  logic [3*NPORTS-1:0]            op;
  logic [DW*NPORTS-1:0]           din;
  logic [NPORTS-1:0]              notfull;
  logic [(DEPTH_P2+1)*NPORTS-1:0] fillcount;
  logic                           out_valid;
  logic [OCW-1:0]                 out_cmd;
  logic [DW-1:0]                  out_data;
  logic                           out_get;
  logic                           ret_put;
  logic [PW-1:0]                  ret_port;
  logic [AW-1:0]                  ret_addr;
  logic [DW-1:0]                  ret_data;
  logic [NPORTS-1:0]              ret_full;
  logic [NPORTS-1:0]              read;
  logic [NPORTS-1:0]              validout;
  logic [AW*NPORTS-1:0]           raddr;
  logic [DW*NPORTS-1:0]           dout;
  logic [NPORTS-1:0]              ovf;

  modport slave (
    input  cmd, addr, sz, op, din, out_get, ret_put, ret_port, ret_addr, ret_data, read,
    output notfull, fillcount, out_valid, out_cmd, out_data, ret_full, validout, raddr, dout, ovf
  );

  modport master (
    output cmd, addr, sz, op, din, out_get, ret_put, ret_port, ret_addr, ret_data, read,
    input  notfull, fillcount, out_valid, out_cmd, out_data, ret_full, validout, raddr, dout, ovf
  );
endinterface

// File: rtl/ddr3_mp_frontend.sv
// Multi-port DDR3 front end: per-port command/write-data FIFOs feeding a
// round-robin arbiter and a single downstream command register, plus
// per-port return FIFOs filled by the memory engine.
module ddr3_mp_frontend #(
  parameter int NPORTS   = 2,
  parameter int DW       = 16,
  parameter int AW       = 26,
  parameter int DEPTH_P2 = 4
) (
  input logic               clk,
  input logic               reset,
  ddr3_mp_frontend_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_P2;
  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CNTW  = DEPTH_P2 + 1;
  localparam int CW    = 3 + AW + 5;   // {cmd, addr, sz, op}
  localparam int RW    = AW + DW;      // {ret_addr, ret_data}
  localparam logic [2:0] SCR = 3'b001;
  localparam logic [2:0] SCW = 3'b010;

  logic [CW-1:0]       cmd_mem [NPORTS][DEPTH];
  logic [DW-1:0]       dat_mem [NPORTS][DEPTH];
  logic [RW-1:0]       ret_mem [NPORTS][DEPTH];
  logic [DEPTH_P2-1:0] c_wr [NPORTS];
  logic [DEPTH_P2-1:0] c_rd [NPORTS];
  logic [DEPTH_P2-1:0] d_wr [NPORTS];
  logic [DEPTH_P2-1:0] d_rd [NPORTS];
  logic [DEPTH_P2-1:0] r_wr [NPORTS];
  logic [DEPTH_P2-1:0] r_rd [NPORTS];
  logic [CNTW-1:0]     c_cnt [NPORTS];
  logic [CNTW-1:0]     d_cnt [NPORTS];
  logic [CNTW-1:0]     r_cnt [NPORTS];

  logic [NPORTS-1:0] acc_ok, c_push, c_pop, d_push, d_pop, r_push, r_pop, ovf_set, ovf_q;
  logic [PW-1:0]     last_grant, grant_p;
  logic              grant, can_load;
  logic              out_valid_q;
  logic [PW+CW-1:0]  out_cmd_q;
  logic [DW-1:0]     out_data_q;

  // Request accept: a port takes SCR/SCW only while both its FIFOs have room.
  always_comb begin
    logic [2:0] pc;
    pc     = 3'b000;
    acc_ok = '0;
    c_push = '0;
    d_push = '0;
    for (int p = 0; p < NPORTS; p++) begin
      pc        = bus.cmd[3*p +: 3];
      acc_ok[p] = (c_cnt[p] != CNTW'(DEPTH)) && (d_cnt[p] != CNTW'(DEPTH));
      c_push[p] = acc_ok[p] && ((pc == SCR) || (pc == SCW));
      d_push[p] = acc_ok[p] && (pc == SCW);
    end
  end

  // Round-robin arbiter: lowest offset from last_grant+1 with a queued command wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = 1'b0;
    grant_p  = '0;
    c_pop    = '0;
    d_pop    = '0;
    can_load = !out_valid_q || bus.out_get;
    for (int i = NPORTS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NPORTS;
      if (c_cnt[idx] != '0) begin
        grant   = 1'b1;
        grant_p = PW'(idx);
      end
    end
    if (can_load && grant) begin
      c_pop[grant_p] = 1'b1;
      d_pop[grant_p] = (cmd_mem[grant_p][c_rd[grant_p]][CW-1 -: 3] == SCW);
    end
  end

  // Return path: a read frees a slot first, so a put to a full FIFO lands if read.
  always_comb begin
    r_push  = '0;
    r_pop   = '0;
    ovf_set = '0;
    for (int p = 0; p < NPORTS; p++) begin
      r_pop[p] = bus.read[p] && (r_cnt[p] != '0);
      if (bus.ret_put && (bus.ret_port == PW'(p))) begin
        if ((r_cnt[p] != CNTW'(DEPTH)) || bus.read[p]) r_push[p] = 1'b1;
        else                                           ovf_set[p] = 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy counters.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (reset) begin
        c_wr[p]  <= '0;
        c_rd[p]  <= '0;
        d_wr[p]  <= '0;
        d_rd[p]  <= '0;
        r_wr[p]  <= '0;
        r_rd[p]  <= '0;
        c_cnt[p] <= '0;
        d_cnt[p] <= '0;
        r_cnt[p] <= '0;
      end else begin
        if (c_push[p]) c_wr[p] <= c_wr[p] + 1'b1;
        if (c_pop[p])  c_rd[p] <= c_rd[p] + 1'b1;
        if (d_push[p]) d_wr[p] <= d_wr[p] + 1'b1;
        if (d_pop[p])  d_rd[p] <= d_rd[p] + 1'b1;
        if (r_push[p]) r_wr[p] <= r_wr[p] + 1'b1;
        if (r_pop[p])  r_rd[p] <= r_rd[p] + 1'b1;
        c_cnt[p] <= c_cnt[p] + CNTW'(c_push[p]) - CNTW'(c_pop[p]);
        d_cnt[p] <= d_cnt[p] + CNTW'(d_push[p]) - CNTW'(d_pop[p]);
        r_cnt[p] <= r_cnt[p] + CNTW'(r_push[p]) - CNTW'(r_pop[p]);
      end
    end
  end

  // FIFO storage; contents need no reset because the counters gate visibility.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (c_push[p]) cmd_mem[p][c_wr[p]] <= {bus.cmd[3*p +: 3], bus.addr[AW*p +: AW],
                                             bus.sz[2*p +: 2], bus.op[3*p +: 3]};
      if (d_push[p]) dat_mem[p][d_wr[p]] <= bus.din[DW*p +: DW];
      if (r_push[p]) ret_mem[p][r_wr[p]] <= {bus.ret_addr, bus.ret_data};
    end
  end

  // Downstream command register, grant history and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_data_q  <= '0;
      last_grant  <= PW'(NPORTS - 1);
      ovf_q       <= '0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      if (can_load) begin
        out_valid_q <= grant;
        if (grant) begin
          out_cmd_q  <= {grant_p, cmd_mem[grant_p][c_rd[grant_p]]};
          out_data_q <= d_pop[grant_p] ? dat_mem[grant_p][d_rd[grant_p]] : '0;
          last_grant <= grant_p;
        end
      end
    end
  end

  // Drive the bus outputs from internal state.
  always_comb begin
    bus.notfull   = acc_ok;
    bus.fillcount = '0;
    bus.ret_full  = '0;
    bus.validout  = '0;
    bus.raddr     = '0;
    bus.dout      = '0;
    for (int p = 0; p < NPORTS; p++) begin
      bus.fillcount[CNTW*p +: CNTW] = c_cnt[p];
      bus.ret_full[p]               = (r_cnt[p] == CNTW'(DEPTH));
      bus.validout[p]               = (r_cnt[p] != '0);
      bus.raddr[AW*p +: AW]         = ret_mem[p][r_rd[p]][RW-1 -: AW];
      bus.dout[DW*p +: DW]          = ret_mem[p][r_rd[p]][DW-1:0];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_cmd   = out_cmd_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/ddr3_mp_frontend.md
DDR3_MP_FRONTEND -- requirements
Module: ddr3_mp_frontend

Parameters
REQ-001 NPORTS, 2, number of client ports (legal 2..4).
REQ-002 DW, 16, data width.
REQ-003 AW, 26, request address width.
REQ-004 DEPTH_P2, 4, log2 of each per-port FIFO depth (legal 2..6).

Interface
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd  in  3*NPORTS  per-port command; 3'b001 = SCR (read), 3'b010 = SCW (write), all other values = idle.
REQ-008 addr  in  AW*NPORTS  per-port request address.
REQ-009 sz  in  2*NPORTS  per-port size field.
REQ-010 op  in  3*NPORTS  per-port op field.
REQ-011 din  in  DW*NPORTS  per-port write data.
REQ-012 notfull  out  NPORTS  per-port accept-ready.
REQ-013 fillcount  out  (DEPTH_P2+1)*NPORTS  per-port command-FIFO occupancy.
REQ-014 out_valid  out  1  downstream command register holds an entry.
REQ-015 out_cmd  out  log2(NPORTS)+3+AW+5  packed {port_id, cmd, addr, sz, op}, with port_id width clog2(NPORTS).
REQ-016 out_data  out  DW  write data paired with out_cmd; 0 for SCR.
REQ-017 out_get  in  1  downstream consumes out_cmd/out_data this cycle.
REQ-018 ret_put  in  1  return beat from memory engine.
REQ-019 ret_port  in  clog2(NPORTS)  destination port of the return beat.
REQ-020 ret_addr / ret_data  in  AW / DW  return address and return data.
REQ-021 ret_full  out  NPORTS  per-port return-FIFO full.
REQ-022 read  in  NPORTS  per-port pop of the return FIFO.
REQ-023 validout  out  NPORTS  per-port return FIFO non-empty.
REQ-024 raddr / dout  out  AW*NPORTS / DW*NPORTS  per-port return FIFO head (show-ahead).
REQ-025 ovf  out  NPORTS  sticky flag, set on return put to a full FIFO.

Function
REQ-026 Each port SHALL own a command FIFO, a write-data FIFO and a return FIFO, each of depth 2^DEPTH_P2.
REQ-027 notfull[p] SHALL be combinational: 1 when both the cmd FIFO and the data FIFO of port p have count < depth.
REQ-028 Accept rule: with notfull[p]=1, SCR SHALL push {cmd, addr, sz, op} to the cmd FIFO only; SCW SHALL push to the cmd FIFO and push din to the data FIFO in the same edge.
REQ-029 With notfull[p]=0, or an idle cmd value, the request SHALL be dropped silently and no FIFO SHALL change.
REQ-030 Output register load condition: out_valid=0, or out_get=1, in the same cycle.
REQ-031 When the output register can load, the arbiter SHALL pick the first non-empty port in the order last_grant+1, last_grant+2, ... (mod NPORTS), pop its cmd FIFO, and pop its data FIFO iff the popped cmd is SCW.
REQ-032 last_grant SHALL update only on a grant.
REQ-033 The output register SHALL load the popped entry with port_id = granted port; out_valid = 1.
REQ-034 If the output register can load and every FIFO is empty: out_get=1 SHALL clear out_valid; otherwise out_valid SHALL hold.
REQ-035 out_cmd/out_data SHALL hold stable while out_valid=1 and out_get=0.
REQ-036 out_get with out_valid=0 SHALL be ignored.
REQ-037 Latency: a request accepted at edge t SHALL appear on out_valid no earlier than after edge t+1, and only when it wins arbitration.
REQ-038 Per-port order SHALL be preserved.
REQ-039 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and SHALL be legal, including at full (pop frees the slot first) and at empty (no pop occurs; push lands).
REQ-040 fillcount[p] SHALL equal the cmd-FIFO count of port p, range 0..2^DEPTH_P2.
REQ-041 Return path: ret_put SHALL push {ret_addr, ret_data} into the return FIFO selected by ret_port.
REQ-042 ret_put to a full return FIFO SHALL drop the beat and set ovf[ret_port] unless read[ret_port]=1 in the same cycle.
REQ-043 ret_port >= NPORTS SHALL drop the beat with no flag.
REQ-044 validout[p] SHALL equal !empty.
REQ-045 read[p] SHALL pop the return FIFO; read on an empty FIFO SHALL be ignored.
REQ-046 Read/write pointers SHALL wrap modulo 2^DEPTH_P2; the count SHALL use DEPTH_P2+1 bits.

Reset
REQ-047 On reset=1 at posedge clk, all FIFOs SHALL empty; out_valid, out_cmd, out_data and ovf SHALL become 0.
REQ-048 On reset, last_grant SHALL become NPORTS-1 so that port 0 wins first; notfull SHALL be all 1; validout and ret_full SHALL be all 0.
REQ-049 Reset SHALL override any concurrent push, pop or out_get, and an in-flight output entry SHALL be discarded.

Verification
REQ-050 Round-robin: NPORTS=2, one SCR on each port in the same cycle (addr 0x10 / 0x20), out_get held 1 -> out_cmd port_id 0 then 1 on consecutive cycles.
REQ-051 Write pairing: port1 SCW addr 0x3, din 0xBEEF -> out_cmd cmd=3'b010, port_id=1, out_data=0xBEEF; port1 data FIFO then empty.
REQ-052 Full: DEPTH_P2=2, out_get=0, 5 SCW on port 0 -> 1 entry in the output register, then 4 queued; notfull[0]=0, fillcount[0]=4; a 6th request is dropped.
REQ-053 Return overflow: fill port-1 return FIFO to 16 (DEPTH_P2=4), ret_put again with read[1]=0 -> ovf[1]=1 and the head is unchanged; the same put with read[1]=1 -> no ovf.
REQ-054 Backpressure: out_valid=1, out_get=0 for 10 cycles with other ports pending -> out_cmd stable; release -> next port in rotation granted.
REQ-055 Mid-operation reset: assert reset with FIFOs half full and out_valid=1 -> next cycle all counts 0, out_valid=0, and the first post-reset grant goes to port 0.
